split_runs: RTL and testbench
=============================

# split_runs

Run distributor for the merge-sort stage of the BWT sorter. It reads rotation rows from a single first-word-fall-through input FIFO, which holds the output of the previous merge pass. It writes them alternately, in runs of `run_len` rows, into the left and right FIFOs that feed the merge stage. It is the writer side of the `FIFO_L`/`FIFO_R` interface that the merge stage reads.

## Interface
Parameters:
- `COLUMN`, 3: bytes per row (rotation length).
- `CNT_LEN`, 4: width of the run-length and row counters; rows per pass at most 2^CNT_LEN-1.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  reset, asynchronous, active-low; one clock domain.
- `start`  in  1  single-cycle pulse; begin a pass. Sampled in IDLE only.
- `run_len`  in  CNT_LEN  rows per run; latched on accepted `start`.
- `num_rows`  in  CNT_LEN  rows in this pass; latched on accepted `start`.
- `empty_FIFO_IN`  in  1  input FIFO empty.
- `array_in`  in  [COLUMN-1:0][7:0]  head row of the input FIFO (FWFT).
- `full_FIFO_L`  in  1  left FIFO full.
- `full_FIFO_R`  in  1  right FIFO full.
- `rd_fifo_in`  out  1  pop the input FIFO.
- `array_out`  out  [COLUMN-1:0][7:0]  row to write; shared by both output FIFOs.
- `wr_fifo_L`  out  1  push `array_out` into the left FIFO.
- `wr_fifo_R`  out  1  push `array_out` into the right FIFO.
- `busy`  out  1  high whenever the state is not IDLE.
- `done`  out  1  one-cycle pulse at the end of a pass.

## Operation
- States: IDLE, ROUTE_L, ROUTE_R, DONE.
- IDLE:
  - `start`=1 with `run_len`≠0 and `num_rows`≠0 latches both values, clears `run_cnt` and `row_cnt`, and moves to ROUTE_L.
  - `start` with either value 0 is ignored: the block stays IDLE and no `done` is generated.
- Transfer in ROUTE_x happens when `!empty_FIFO_IN && !full_FIFO_x`. In that cycle:
  - `rd_fifo_in`=1 and `wr_fifo_x`=1, combinationally.
  - The other side's write strobe is 0.
  - `array_out`=`array_in`.
- No transfer condition: all strobes 0 and `array_out`=0. The block stalls in its current state with counters held.
- Counter update on each transfer:
  - `row_cnt`+1 and `run_cnt`+1.
  - If `run_cnt`==`run_len`-1: clear `run_cnt` and switch to the other ROUTE state.
- Final row: a transfer with `row_cnt`==`num_rows`-1 goes to DONE. This overrides the run switch, and counters clear.
  - A final run shorter than `run_len` is therefore legal.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- `start` while busy is ignored, including in DONE.
- Full on the other side never affects the current side.
  - A stall on the current side never causes an early switch; runs stay contiguous.
- Counter arithmetic is unsigned CNT_LEN-bit. Comparisons use latched values, so changing `run_len` or `num_rows` mid-pass has no effect.
- Reset (asserted at any time, including mid-pass): state becomes IDLE and counters and latched values clear. All outputs go to 0 immediately, without waiting for a clock.
  - Rows already pushed stay in the output FIFOs. Flushing them is the controller's job.

## Timing
- Reset values: `rd_fifo_in`=0, `wr_fifo_L`=0, `wr_fifo_R`=0, `array_out`=0, `busy`=0, `done`=0.
- `start` is accepted at edge k, the state is ROUTE_L from cycle k+1, and the first transfer is possible in cycle k+1.
- Throughput is one row per cycle with no bubble at a side switch. With no stalls, a pass of N rows transfers in cycles k+1..k+N.
- `done` is high in cycle k+N+1. `busy` is high in cycles k+1..k+N+1.
- `rd_fifo_in` and `wr_fifo_x` are combinational, in the same cycle as the flags. They are never asserted when the corresponding empty or full flag is high.
- `wr_fifo_L` and `wr_fifo_R` are never both 1.

## Test plan
- `num_rows`=8, `run_len`=2, no stalls, input rows 0..7 → L receives 0,1,4,5 and R receives 2,3,6,7; `done` is 8 cycles after the first transfer, then `busy`=0.
- `num_rows`=8, `run_len`=3 → L receives 0,1,2,6,7 and R receives 3,4,5 (short final run); exactly 8 reads and 8 writes.
- `full_FIFO_R` held high for 5 cycles just as the block enters ROUTE_R → no strobes during the stall, no switch back to L, counters held; the row order matches the first scenario.
- `empty_FIFO_IN` toggling every other cycle → transfers occur only on non-empty cycles; the final routing matches the no-stall case.
- Reset asserted low after 3 transfers → outputs are 0 asynchronously; after release, a new `start` with `num_rows`=4, `run_len`=1 gives L 0,2 and R 1,3.
- `start` with `run_len`=0, then `start` while busy → both are ignored; no extra reads and no `done`.

Source files
------------

// File: rtl/split_runs.sv
// Run distributor for the BWT merge-sort stage: moves rows from one FWFT input FIFO
// into the left/right merge FIFOs in alternating runs of run_len rows.
module split_runs #(
    parameter int COLUMN  = 3,
    parameter int CNT_LEN = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [CNT_LEN-1:0]     run_len,
    input  logic [CNT_LEN-1:0]     num_rows,
    input  logic                   empty_FIFO_IN,
    input  logic [COLUMN-1:0][7:0] array_in,
    input  logic                   full_FIFO_L,
    input  logic                   full_FIFO_R,
    output logic                   rd_fifo_in,
    output logic [COLUMN-1:0][7:0] array_out,
    output logic                   wr_fifo_L,
    output logic                   wr_fifo_R,
    output logic                   busy,
    output logic                   done
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ROUTE_L = 2'd1;
    localparam logic [1:0] S_ROUTE_R = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    localparam logic [CNT_LEN-1:0] CNT_ZERO = {CNT_LEN{1'b0}};
    localparam logic [CNT_LEN-1:0] CNT_ONE  = {{(CNT_LEN-1){1'b0}}, 1'b1};

    logic [1:0]         state_q,    state_d;
    logic [CNT_LEN-1:0] run_len_q,  run_len_d;
    logic [CNT_LEN-1:0] num_rows_q, num_rows_d;
    logic [CNT_LEN-1:0] run_cnt_q,  run_cnt_d;
    logic [CNT_LEN-1:0] row_cnt_q,  row_cnt_d;

    logic routing_s;
    logic side_full_s;
    logic xfer_s;

    // Transfer qualification: only the full flag of the side being filled matters.
    always_comb begin
        routing_s   = (state_q == S_ROUTE_L) || (state_q == S_ROUTE_R);
        if (state_q == S_ROUTE_R) begin
            side_full_s = full_FIFO_R;
        end else begin
            side_full_s = full_FIFO_L;
        end
        xfer_s      = routing_s && !empty_FIFO_IN && !side_full_s;
    end

    // Strobes and data are combinational so a row moves in the cycle its flags allow it.
    always_comb begin
        rd_fifo_in = xfer_s;
        wr_fifo_L  = xfer_s && (state_q == S_ROUTE_L);
        wr_fifo_R  = xfer_s && (state_q == S_ROUTE_R);
        if (xfer_s) begin
            array_out = array_in;
        end else begin
            array_out = '0;
        end
        busy = (state_q != S_IDLE);
        done = (state_q == S_DONE);
    end

    // Next-state and counter logic.
    always_comb begin
        state_d    = state_q;
        run_len_d  = run_len_q;
        num_rows_d = num_rows_q;
        run_cnt_d  = run_cnt_q;
        row_cnt_d  = row_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start && (run_len != CNT_ZERO) && (num_rows != CNT_ZERO)) begin
                    run_len_d  = run_len;
                    num_rows_d = num_rows;
                    run_cnt_d  = CNT_ZERO;
                    row_cnt_d  = CNT_ZERO;
                    state_d    = S_ROUTE_L;
                end else begin
                    state_d    = S_IDLE;
                end
            end
            S_ROUTE_L, S_ROUTE_R: begin
                if (!xfer_s) begin
                    state_d = state_q;
                end else if (row_cnt_q == (num_rows_q - CNT_ONE)) begin
                    // The last row ends the pass even in the middle of a run.
                    run_cnt_d = CNT_ZERO;
                    row_cnt_d = CNT_ZERO;
                    state_d   = S_DONE;
                end else if (run_cnt_q == (run_len_q - CNT_ONE)) begin
                    run_cnt_d = CNT_ZERO;
                    row_cnt_d = row_cnt_q + CNT_ONE;
                    if (state_q == S_ROUTE_L) begin
                        state_d = S_ROUTE_R;
                    end else begin
                        state_d = S_ROUTE_L;
                    end
                end else begin
                    run_cnt_d = run_cnt_q + CNT_ONE;
                    row_cnt_d = row_cnt_q + CNT_ONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            run_len_q  <= CNT_ZERO;
            num_rows_q <= CNT_ZERO;
            run_cnt_q  <= CNT_ZERO;
            row_cnt_q  <= CNT_ZERO;
        end else begin
            state_q    <= state_d;
            run_len_q  <= run_len_d;
            num_rows_q <= num_rows_d;
            run_cnt_q  <= run_cnt_d;
            row_cnt_q  <= row_cnt_d;
        end
    end

endmodule

// File: tb/tb_split_runs.sv
// Bench for split_runs: random rows and stalls, checked cycle by cycle against a
// row-index model (row i goes left when (i / run_len) is even).
module tb_split_runs;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic [3:0]       run_len = 4'd0;
    logic [3:0]       num_rows = 4'd0;
    logic             empty_FIFO_IN = 1'b1;
    logic [2:0][7:0]  array_in = '0;
    logic             full_FIFO_L = 1'b0;
    logic             full_FIFO_R = 1'b0;
    logic             rd_fifo_in;
    logic [2:0][7:0]  array_out;
    logic             wr_fifo_L;
    logic             wr_fifo_R;
    logic             busy;
    logic             done;

    split_runs #(.COLUMN(3), .CNT_LEN(4)) dut (
        .clk(clk), .rst(rst), .start(start), .run_len(run_len), .num_rows(num_rows),
        .empty_FIFO_IN(empty_FIFO_IN), .array_in(array_in),
        .full_FIFO_L(full_FIFO_L), .full_FIFO_R(full_FIFO_R),
        .rd_fifo_in(rd_fifo_in), .array_out(array_out),
        .wr_fifo_L(wr_fifo_L), .wr_fifo_R(wr_fifo_R), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [23:0] in_q[$];
    logic [23:0] pass_rows[$];
    logic [23:0] got_L[$];
    logic [23:0] got_R[$];
    int n_rd;
    logic force_empty = 1'b0;
    logic force_full_L = 1'b0;
    logic force_full_R = 1'b0;

    bit m_active = 1'b0;
    bit m_done   = 1'b0;
    int m_k = 0;
    int m_R = 1;
    int m_N = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        logic exp_x;
        logic side_r;
        logic [23:0] exp_row;
        empty_FIFO_IN = force_empty || (in_q.size() == 0);
        array_in      = (in_q.size() != 0) ? in_q[0] : 24'($urandom);
        full_FIFO_L   = force_full_L;
        full_FIFO_R   = force_full_R;
        @(negedge clk);
        side_r  = (((m_k / m_R) % 2) == 1);
        exp_x   = m_active && !empty_FIFO_IN && !(side_r ? full_FIFO_R : full_FIFO_L);
        exp_row = exp_x ? in_q[0] : 24'h0;
        chk("rd_fifo_in", 32'(rd_fifo_in), 32'(exp_x));
        chk("wr_fifo_L", 32'(wr_fifo_L), 32'(exp_x && !side_r));
        chk("wr_fifo_R", 32'(wr_fifo_R), 32'(exp_x && side_r));
        chk("array_out", 32'(array_out), 32'(exp_row));
        chk("busy", 32'(busy), 32'(m_active || m_done));
        chk("done", 32'(done), 32'(m_done));
        if (wr_fifo_L) got_L.push_back(array_out);
        if (wr_fifo_R) got_R.push_back(array_out);
        if (rd_fifo_in) n_rd++;
        @(posedge clk);
        if (m_done) begin
            m_done = 1'b0;
        end else if (m_active) begin
            if (exp_x) begin
                void'(in_q.pop_front());
                m_k++;
                if (m_k == m_N) begin
                    m_active = 1'b0;
                    m_done   = 1'b1;
                end
            end
        end else if (start && run_len != 4'd0 && num_rows != 4'd0) begin
            m_active = 1'b1;
            m_k = 0;
            m_R = int'(run_len);
            m_N = int'(num_rows);
        end
        #1;
    endtask

    task automatic load_rows(input int n);
        in_q.delete();
        pass_rows.delete();
        got_L.delete();
        got_R.delete();
        n_rd = 0;
        for (int i = 0; i < n; i++) begin
            pass_rows.push_back({16'($urandom), 8'(i)});
            in_q.push_back(pass_rows[i]);
        end
    endtask

    task automatic check_routing(input string tag, input int n, input int r);
        logic [23:0] exp_L[$];
        logic [23:0] exp_R[$];
        for (int i = 0; i < n; i++) begin
            if (((i / r) % 2) == 0) exp_L.push_back(pass_rows[i]);
            else exp_R.push_back(pass_rows[i]);
        end
        chk({tag, "_nL"}, 32'(got_L.size()), 32'(exp_L.size()));
        chk({tag, "_nR"}, 32'(got_R.size()), 32'(exp_R.size()));
        chk({tag, "_nrd"}, 32'(n_rd), 32'(n));
        for (int i = 0; i < exp_L.size() && i < got_L.size(); i++)
            chk({tag, "_L"}, 32'(got_L[i]), 32'(exp_L[i]));
        for (int i = 0; i < exp_R.size() && i < got_R.size(); i++)
            chk({tag, "_R"}, 32'(got_R[i]), 32'(exp_R[i]));
    endtask

    // mode: 0 none, 1 full_R stall on entering R, 2 empty toggling, 3 random, 4 start while busy
    task automatic run_pass(input string tag, input int mode, input int n, input int r);
        int cyc = 0;
        int stall = 0;
        load_rows(n);
        start = 1'b1; run_len = 4'(r); num_rows = 4'(n);
        cycle();
        start = 1'b0;
        run_len = 4'($urandom); num_rows = 4'($urandom);
        while ((m_active || m_done) && cyc < 300) begin
            force_empty  = 1'b0;
            force_full_L = 1'b0;
            force_full_R = 1'b0;
            start        = 1'b0;
            case (mode)
                1: if (m_k >= r && stall < 5) begin force_full_R = 1'b1; stall++; end
                2: force_empty = (cyc % 2 == 1);
                3: begin
                    force_empty  = ($urandom_range(3) == 0);
                    force_full_L = ($urandom_range(3) == 0);
                    force_full_R = ($urandom_range(3) == 0);
                end
                4: start = (cyc == 2) || m_done;
                default: start = 1'b0;
            endcase
            cycle();
            cyc++;
        end
        start = 1'b0; force_empty = 1'b0; force_full_L = 1'b0; force_full_R = 1'b0;
        chk({tag, "_timeout"}, 32'(cyc < 300), 32'd1);
        check_routing(tag, n, r);
    endtask

    initial begin
        #2;
        chk("rst_rd", 32'(rd_fifo_in), 32'd0);
        chk("rst_wr", 32'({wr_fifo_L, wr_fifo_R}), 32'd0);
        chk("rst_data", 32'(array_out), 32'd0);
        chk("rst_busy_done", 32'({busy, done}), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        cycle();

        run_pass("p8r2", 0, 8, 2);
        run_pass("p8r3", 0, 8, 3);
        run_pass("stallR", 1, 8, 2);
        run_pass("emptytog", 2, 8, 2);

        // reset in the middle of a pass, with a transfer pending
        begin
            int cyc = 0;
            load_rows(8);
            start = 1'b1; run_len = 4'd2; num_rows = 4'd8;
            cycle();
            start = 1'b0;
            while (m_k < 3 && cyc < 50) begin cycle(); cyc++; end
            chk("rst_mid_reach", 32'(m_k), 32'd3);
            empty_FIFO_IN = 1'b0; full_FIFO_L = 1'b0; full_FIFO_R = 1'b0;
            array_in = in_q[0];
            rst = 1'b0;
            #1;
            chk("arst_rd", 32'(rd_fifo_in), 32'd0);
            chk("arst_wr", 32'({wr_fifo_L, wr_fifo_R}), 32'd0);
            chk("arst_data", 32'(array_out), 32'd0);
            chk("arst_busy_done", 32'({busy, done}), 32'd0);
            chk("arst_gotL", 32'(got_L.size()), 32'd2);
            chk("arst_gotR", 32'(got_R.size()), 32'd1);
            m_active = 1'b0; m_done = 1'b0;
            @(posedge clk); #1;
            rst = 1'b1;
            in_q.delete();
            cycle();
        end
        run_pass("after_rst", 0, 4, 1);

        // ignored starts: zero run_len / zero num_rows
        load_rows(5);
        start = 1'b1; run_len = 4'd0; num_rows = 4'd5;
        cycle();
        run_len = 4'd3; num_rows = 4'd0;
        cycle();
        start = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        chk("ign_zero_rd", 32'(n_rd), 32'd0);

        run_pass("busy_start", 4, 5, 2);
        for (int i = 0; i < 3; i++) cycle();
        chk("busy_start_idle", 32'(busy), 32'd0);

        run_pass("full_len", 0, 15, 15);
        for (int t = 0; t < 8; t++) begin
            run_pass("rand", 3, $urandom_range(1, 15), $urandom_range(1, 15));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
